// File: rtl/regfile_arb_pkg.sv
// Shared defaults and FSM state type for the register-file write arbiter.
package regfile_arb_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned ADDR_W_DEFAULT = 3;
   localparam int unsigned LEN_W_DEFAULT  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time is chosen.
module rr_picker (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      if (req0 && req1) begin
         grant_idx = ~last_owner;
      end else begin
         grant_idx = req1;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two burst-write requesters onto one register-file write port.
// A grant costs one IDLE cycle; each accepted beat is written one cycle after its ack.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              ack0,
   output logic              ack1,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              owner
);

   arb_state_e        state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              last_owner_q, last_owner_d;
   logic              owner_q, owner_d;
   logic              busy_q;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic grant_valid;
   logic grant_idx;
   logic owner_req;
   logic beat_ok;

   rr_picker u_rr_picker (
      .req0        (req0),
      .req1        (req1),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign owner_req = owner_q ? req1 : req0;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      beat_ok      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = BURST;
               owner_d = grant_idx;
               cnt_d   = grant_idx ? len1 : len0;
            end
         end
         BURST: begin
            if (owner_req) begin
               beat_ok   = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = owner_q ? addr1 : addr0;
               wr_data_d = owner_q ? data1 : data0;
               if (cnt_q == '0) begin
                  state_d      = IDLE;
                  last_owner_d = owner_q;
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
               end
            end else begin
               // Owner withdrew mid-burst: abandon remaining beats.
               state_d      = IDLE;
               last_owner_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ack0 = beat_ok & ~reset & ~owner_q;
   assign ack1 = beat_ok & ~reset & owner_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_owner_q <= 1'b1;
         owner_q      <= 1'b0;
         busy_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         busy_q       <= (state_d == BURST);
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign owner   = owner_q;

endmodule
